// File: rtl/i2c_regmap_ctrl.sv
// Byte-addressed register map behind the i2c_simple_slave strobe interface.
// A write transaction sets a persistent pointer then writes bytes with
// auto-increment; a read transaction prefetches from an external read port,
// stretching SCL for one cycle per byte while the prefetch settles.
module i2c_regmap_ctrl #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter logic [7:0]  REG_RESET  = 8'h00
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        i2c_addr_rw,
  input  logic                              i2c_addr_rw_valid_stb,
  input  logic [7:0]                        i2c_data_rx,
  input  logic                              i2c_data_rx_valid_stb,
  output logic [7:0]                        i2c_data_tx,
  input  logic                              i2c_data_tx_loaded_stb,
  input  logic                              i2c_data_tx_done_stb,
  input  logic                              i2c_error_stb,
  output logic                              stall,
  output logic [8*(2**REG_ADDR_W)-1:0]      regs_flat,
  output logic                              wr_stb,
  output logic [REG_ADDR_W-1:0]             wr_idx,
  output logic [7:0]                        wr_data,
  output logic [REG_ADDR_W-1:0]             rd_idx,
  input  logic [7:0]                        rd_data,
  output logic [7:0]                        err_count
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StPtr,
    StWdata,
    StRprep,
    StRdata
  } state_e;

  state_e                r_state;
  logic [REG_ADDR_W-1:0] r_ptr;
  logic [7:0]            r_regs [NUM_REGS];
  logic [7:0]            r_data_tx;
  logic                  r_wr_stb;
  logic [REG_ADDR_W-1:0] r_wr_idx;
  logic [7:0]            r_wr_data;
  logic [7:0]            r_err_count;

  // tx_done is informational and the address bits above R/W are already matched by the slave
  logic w_unused;
  assign w_unused = ^{i2c_data_tx_done_stb, i2c_addr_rw[7:1], i2c_data_rx};

  // Sequencer: error beats address strobe, address strobe beats per-state data strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_data_tx   <= 8'h00;
      r_wr_stb    <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_data   <= 8'h00;
      r_err_count <= 8'h00;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= REG_RESET;
      end
    end else begin
      r_wr_stb <= 1'b0;
      if (i2c_error_stb) begin
        r_state <= StIdle;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end else if (i2c_addr_rw_valid_stb) begin
        // Also covers repeated START; pointer is deliberately left alone
        r_state <= i2c_addr_rw[0] ? StRprep : StPtr;
      end else begin
        case (r_state)
          StPtr: begin
            if (i2c_data_rx_valid_stb) begin
              r_ptr   <= i2c_data_rx[REG_ADDR_W-1:0];
              r_state <= StWdata;
            end
          end
          StWdata: begin
            if (i2c_data_rx_valid_stb) begin
              r_regs[r_ptr] <= i2c_data_rx;
              r_wr_stb      <= 1'b1;
              r_wr_idx      <= r_ptr;
              r_wr_data     <= i2c_data_rx;
              r_ptr         <= r_ptr + 1'b1;
            end
          end
          StRprep: begin
            // rd_data is combinational on rd_idx = r_ptr, so one cycle suffices
            r_data_tx <= rd_data;
            r_state   <= StRdata;
          end
          StRdata: begin
            if (i2c_data_tx_loaded_stb) begin
              r_ptr   <= r_ptr + 1'b1;
              r_state <= StRprep;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Flatten the register file onto the output bus
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[8*k +: 8] = r_regs[k];
  end

  assign stall       = (r_state == StRprep);
  assign rd_idx      = r_ptr;
  assign i2c_data_tx = r_data_tx;
  assign wr_stb      = r_wr_stb;
  assign wr_idx      = r_wr_idx;
  assign wr_data     = r_wr_data;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_i2c_regmap_ctrl.sv
// Bench for i2c_regmap_ctrl: directed scenarios followed by random transactions,
// all checked against a transaction-level model of pointer, registers and error count.
module tb_i2c_regmap_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned NR = 8;
  localparam logic [7:0]  RV = 8'h3C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    i2c_addr_rw;
  logic          i2c_addr_rw_valid_stb;
  logic [7:0]    i2c_data_rx;
  logic          i2c_data_rx_valid_stb;
  logic [7:0]    i2c_data_tx;
  logic          i2c_data_tx_loaded_stb;
  logic          i2c_data_tx_done_stb;
  logic          i2c_error_stb;
  logic          stall;
  logic [8*NR-1:0] regs_flat;
  logic          wr_stb;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_idx;
  logic [7:0]    rd_data;
  logic [7:0]    err_count;

  logic [7:0] rom [NR];
  assign rd_data = rom[rd_idx];

  always #5 clk = ~clk;

  i2c_regmap_ctrl #(
    .REG_ADDR_W (AW),
    .REG_RESET  (RV)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .i2c_addr_rw            (i2c_addr_rw),
    .i2c_addr_rw_valid_stb  (i2c_addr_rw_valid_stb),
    .i2c_data_rx            (i2c_data_rx),
    .i2c_data_rx_valid_stb  (i2c_data_rx_valid_stb),
    .i2c_data_tx            (i2c_data_tx),
    .i2c_data_tx_loaded_stb (i2c_data_tx_loaded_stb),
    .i2c_data_tx_done_stb   (i2c_data_tx_done_stb),
    .i2c_error_stb          (i2c_error_stb),
    .stall                  (stall),
    .regs_flat              (regs_flat),
    .wr_stb                 (wr_stb),
    .wr_idx                 (wr_idx),
    .wr_data                (wr_data),
    .rd_idx                 (rd_idx),
    .rd_data                (rd_data),
    .err_count              (err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 idle, 1 awaiting pointer byte, 2 writing, 3 reading
  int          m_mode;
  int unsigned m_ptr;
  logic [7:0]  m_regs [NR];
  int unsigned m_err;

  function automatic logic [63:0] model_flat();
    logic [63:0] p;
    p = '0;
    for (int k = 0; k < NR; k++) p[8*k +: 8] = m_regs[k];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_ptr  = 0;
    m_err  = 0;
    for (int k = 0; k < NR; k++) m_regs[k] = RV;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_addr(input logic [7:0] a);
    @(negedge clk);
    i2c_addr_rw = a;
    i2c_addr_rw_valid_stb = 1'b1;
    @(negedge clk);
    i2c_addr_rw_valid_stb = 1'b0;
    if (a[0]) begin
      m_mode = 3;
      chk("prep_stall", stall, 1);
      chk("prep_rd_idx", rd_idx, m_ptr);
      @(negedge clk);
      chk("rdata_stall", stall, 0);
      chk("tx_byte", i2c_data_tx, rom[m_ptr]);
    end else begin
      m_mode = 1;
      chk("ptr_stall", stall, 0);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic with_err);
    @(negedge clk);
    i2c_data_rx = b;
    i2c_data_rx_valid_stb = 1'b1;
    i2c_error_stb = with_err;
    @(negedge clk);
    i2c_data_rx_valid_stb = 1'b0;
    i2c_error_stb = 1'b0;
    if (with_err) begin
      m_mode = 0;
      if (m_err < 255) m_err++;
      chk("err_wr_stb", wr_stb, 0);
    end else if (m_mode == 1) begin
      m_ptr  = b % NR;
      m_mode = 2;
      chk("ptr_wr_stb", wr_stb, 0);
    end else if (m_mode == 2) begin
      chk("wr_stb", wr_stb, 1);
      chk("wr_idx", wr_idx, m_ptr);
      chk("wr_data", wr_data, b);
      m_regs[m_ptr] = b;
      m_ptr = (m_ptr + 1) % NR;
    end else begin
      chk("stray_rx_wr_stb", wr_stb, 0);
    end
    chk("regs_flat", regs_flat, model_flat());
    chk("rd_idx", rd_idx, m_ptr);
    chk("err_count", err_count, m_err);
  endtask

  task automatic send_txl();
    @(negedge clk);
    i2c_data_tx_loaded_stb = 1'b1;
    @(negedge clk);
    i2c_data_tx_loaded_stb = 1'b0;
    if (m_mode == 3) begin
      m_ptr = (m_ptr + 1) % NR;
      chk("txl_stall", stall, 1);
      chk("txl_rd_idx", rd_idx, m_ptr);
      @(negedge clk);
      chk("txl_stall_release", stall, 0);
      chk("txl_tx_byte", i2c_data_tx, rom[m_ptr]);
    end else begin
      chk("stray_txl_stall", stall, 0);
      chk("stray_txl_rd_idx", rd_idx, m_ptr);
    end
  endtask

  task automatic send_err(input logic check);
    @(negedge clk);
    i2c_error_stb = 1'b1;
    @(negedge clk);
    i2c_error_stb = 1'b0;
    m_mode = 0;
    if (m_err < 255) m_err++;
    if (check) begin
      chk("err_cnt_step", err_count, m_err);
      chk("err_stall", stall, 0);
    end
  endtask

  task automatic send_done();
    logic [7:0] tx_before;
    tx_before = i2c_data_tx;
    @(negedge clk);
    i2c_data_tx_done_stb = 1'b1;
    @(negedge clk);
    i2c_data_tx_done_stb = 1'b0;
    chk("done_stall", stall, 0);
    chk("done_tx_hold", i2c_data_tx, (m_mode == 3) ? rom[m_ptr] : tx_before);
    chk("done_regs", regs_flat, model_flat());
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    i2c_addr_rw = 8'h00;
    i2c_addr_rw_valid_stb = 1'b0;
    i2c_data_rx = 8'h00;
    i2c_data_rx_valid_stb = 1'b0;
    i2c_data_tx_loaded_stb = 1'b0;
    i2c_data_tx_done_stb = 1'b0;
    i2c_error_stb = 1'b0;
    for (int k = 0; k < NR; k++) rom[k] = 8'h10 + 8'(k);

    do_reset();
    chk("rst_stall", stall, 0);
    chk("rst_regs", regs_flat, {NR{RV}});
    chk("rst_tx", i2c_data_tx, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_err", err_count, 0);

    // Write transaction: reg2=A5, reg3=5A, pointer lands on 4
    send_addr(8'h84);
    send_rx(8'h02, 1'b0);
    send_rx(8'hA5, 1'b0);
    send_rx(8'h5A, 1'b0);
    chk("wr_reg2", regs_flat[23:16], 8'hA5);
    chk("wr_reg3", regs_flat[31:24], 8'h5A);
    chk("wr_ptr4", rd_idx, 4);

    // Read after pointer set: 16, 17, then wrap to 0
    send_addr(8'h84);
    send_rx(8'h06, 1'b0);
    send_addr(8'h85);
    chk("rd_first", i2c_data_tx, 8'h16);
    send_txl();
    chk("rd_second", i2c_data_tx, 8'h17);
    send_txl();
    chk("rd_wrap_ptr", rd_idx, 0);

    // Wrap write
    send_addr(8'h84);
    send_rx(8'h07, 1'b0);
    send_rx(8'h11, 1'b0);
    send_rx(8'h22, 1'b0);
    chk("wrap_reg7", regs_flat[63:56], 8'h11);
    chk("wrap_reg0", regs_flat[7:0], 8'h22);

    // Pointer masking
    send_addr(8'h84);
    send_rx(8'hFB, 1'b0);
    chk("mask_ptr", rd_idx, 3);

    // Error coincident with a data write, then stray rx in idle
    do_reset();
    send_addr(8'h84);
    send_rx(8'h01, 1'b0);
    send_rx(8'h99, 1'b1);
    chk("err_one", err_count, 1);
    send_rx(8'h77, 1'b0);
    for (int i = 0; i < 300; i++) send_err(1'b0);
    chk("err_sat", err_count, 8'hFF);

    // Random transactions
    do_reset();
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          send_addr({7'h42, 1'b0});
          send_rx(8'($urandom), 1'b0);
          n = $urandom_range(1, 5);
          for (int j = 0; j < n; j++) send_rx(8'($urandom), 1'b0);
        end
        1: begin
          for (int k = 0; k < NR; k++) rom[k] = 8'($urandom);
          send_addr({7'h42, 1'b1});
          n = $urandom_range(1, 5);
          for (int j = 0; j < n; j++) send_txl();
        end
        2: begin
          send_addr({7'h42, 1'b1});
          send_rx(8'($urandom), 1'b0);
          send_txl();
        end
        3: send_rx(8'($urandom), 1'b1);
        4: begin
          send_txl();
          send_rx(8'($urandom), 1'b0);
        end
        default: send_done();
      endcase
    end
    chk("rand_regs", regs_flat, model_flat());
    chk("rand_err", err_count, m_err);

    // Async reset while stalled in the prefetch cycle
    send_addr(8'h84);
    send_rx(8'h05, 1'b0);
    send_rx(8'hC3, 1'b0);
    send_err(1'b1);
    @(negedge clk);
    i2c_addr_rw = 8'h85;
    i2c_addr_rw_valid_stb = 1'b1;
    @(negedge clk);
    i2c_addr_rw_valid_stb = 1'b0;
    chk("arst_pre_stall", stall, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_regs", regs_flat, model_flat());
    chk("arst_ptr", rd_idx, 0);
    chk("arst_err", err_count, 0);
    chk("arst_tx", i2c_data_tx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_after_stall", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
